// File: rtl/reg_control_uart_arb_if.sv
// Bus bundle for reg_control_uart_arb: NSRC write sources in, one
// valid/ready command stream out to the UART, plus FIFO status.
//   slave  : seen by the arbiter/FIFO (drives ack, out, status)
//   master : seen by the sources/consumer (drives wr, data, ready)
interface reg_control_uart_arb_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [NSRC-1:0]       wr_i;
  logic [NSRC*WIDTH-1:0] data_i;
  logic [NSRC-1:0]       ack_o;
  logic [WIDTH-1:0]      out_o;
  logic                  valid_o;
  logic                  ready_i;
  logic                  full_o;
  logic                  empty_o;
  logic [CW-1:0]         count_o;
  logic [15:0]           ovf_cnt_o;

  modport slave (
    input  wr_i, data_i, ready_i,
    output ack_o, out_o, valid_o, full_o, empty_o, count_o, ovf_cnt_o
  );

  modport master (
    output wr_i, data_i, ready_i,
    input  ack_o, out_o, valid_o, full_o, empty_o, count_o, ovf_cnt_o
  );
endinterface

// File: rtl/reg_control_uart_arb.sv
// UART command register front-end: NSRC write sources arbitrate (fixed
// priority or round-robin) into a DEPTH-entry first-word-fall-through FIFO
// that drains to the UART transmitter over valid/ready.
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   bus.slave   wr_i/data_i/ack_o (sources), out_o/valid_o/ready_i (UART),
//               full_o/empty_o/count_o/ovf_cnt_o (status)
// Optional feature: define REG_CTRL_UART_OVF_CNT_EN to enable the
// saturating blocked-request counter on ovf_cnt_o (tied to 0 otherwise).
module reg_control_uart_arb #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NSRC      = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned HOLD_LAST = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  reg_control_uart_arb_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    last_grant;
  logic [SW-1:0]    grant_idx;
  logic [SW-1:0]    cand;
  logic             grant_vld;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] last_pop;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // count alone decides full/empty; pointers only address the storage
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = grant_vld && !full && !rst_i;
  assign pop   = !empty && bus.ready_i;

  // Arbiter: scan from index 0 (fixed) or from last_grant+1 (round-robin)
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (ARB_MODE == 1) begin
        cand = SW'((32'(last_grant) + 32'd1 + k) % NSRC);
      end else begin
        cand = SW'(k);
      end
      if (!grant_vld && bus.wr_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the granted source's word
  always_comb begin
    wr_data = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      if (grant_idx == SW'(s)) begin
        wr_data = bus.data_i[s*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.ack_o = push ? (NSRC'(1) << grant_idx) : '0;

  // Storage has no reset; occupancy is tracked by count
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, arbitration history and last-popped word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= SW'(NSRC - 1);
      last_pop   <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_grant <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        if (HOLD_LAST != 0) begin
          last_pop <= mem[rd_ptr];
        end
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // First-word-fall-through output
  assign bus.out_o   = !empty ? mem[rd_ptr] : ((HOLD_LAST != 0) ? last_pop : '0);
  assign bus.valid_o = !empty;
  assign bus.full_o  = full;
  assign bus.empty_o = empty;
  assign bus.count_o = count;

`ifdef REG_CTRL_UART_OVF_CNT_EN
  logic [15:0] ovf_cnt;

  // Saturating count of cycles where a request meets a full FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_cnt <= '0;
    end else if ((|bus.wr_i) && full && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign bus.ovf_cnt_o = ovf_cnt;
`else
  assign bus.ovf_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_reg_control_uart_arb.sv
// Bench for reg_control_uart_arb: two instances (NSRC=2 fixed priority,
// HOLD_LAST=0; NSRC=3 round-robin, HOLD_LAST=1) driven by directed phases
// and $urandom traffic, compared every cycle against a list-based model.
module tb_reg_control_uart_arb;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  reg_control_uart_arb_if #(.WIDTH(W), .NSRC(2), .DEPTH(DEPTH)) bus0 ();
  reg_control_uart_arb_if #(.WIDTH(W), .NSRC(3), .DEPTH(DEPTH)) bus1 ();

  reg_control_uart_arb #(.WIDTH(W), .NSRC(2), .DEPTH(DEPTH), .ARB_MODE(0), .HOLD_LAST(0))
    dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus0));
  reg_control_uart_arb #(.WIDTH(W), .NSRC(3), .DEPTH(DEPTH), .ARB_MODE(1), .HOLD_LAST(1))
    dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus1));

  // Source / consumer stimulus per instance
  logic [2:0]   wr  [2];
  logic [W-1:0] dat [2][3];
  logic         rdy [2];

  assign bus0.wr_i    = wr[0][1:0];
  assign bus0.data_i  = {dat[0][1], dat[0][0]};
  assign bus0.ready_i = rdy[0];
  assign bus1.wr_i    = wr[1];
  assign bus1.data_i  = {dat[1][2], dat[1][1], dat[1][0]};
  assign bus1.ready_i = rdy[1];

  // Reference model: ordered list of queued words, head at index 0
  logic [W-1:0] ml [2][DEPTH];
  int           msz     [2];
  int           lastg   [2];
  logic [W-1:0] lastpop [2];
  int           ovf     [2];
  int           g_pend  [2];
  bit           pop_pend[2];
  bit           blk_pend[2];

  int nchk  = 0;
  int npass = 0;

  function automatic int nsrc(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic bit rr(input int d);
    return d == 1;
  endfunction

  function automatic bit hold(input int d);
    return d == 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Which source the rules say wins this cycle; -1 when nobody is accepted
  function automatic int exp_grant(input int d);
    int s;
    if (rst_i || msz[d] == int'(DEPTH)) return -1;
    for (int k = 0; k < nsrc(d); k++) begin
      s = rr(d) ? (lastg[d] + 1 + k) % nsrc(d) : k;
      if (wr[d][s]) return s;
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    msz[d]     = 0;
    lastg[d]   = nsrc(d) - 1;
    lastpop[d] = '0;
    ovf[d]     = 0;
  endtask

  task automatic check_dut(input int d);
    logic [2:0]    a;
    logic [W-1:0]  o;
    logic          v, f, e;
    logic [CW-1:0] c;
    logic [15:0]   ov;
    logic [W-1:0]  eo;
    int            eovf;
    if (d == 0) begin
      a = {1'b0, bus0.ack_o}; o = bus0.out_o; v = bus0.valid_o; f = bus0.full_o;
      e = bus0.empty_o; c = bus0.count_o; ov = bus0.ovf_cnt_o;
    end else begin
      a = bus1.ack_o; o = bus1.out_o; v = bus1.valid_o; f = bus1.full_o;
      e = bus1.empty_o; c = bus1.count_o; ov = bus1.ovf_cnt_o;
    end
    eo = (msz[d] > 0) ? ml[d][0] : (hold(d) ? lastpop[d] : '0);
`ifdef REG_CTRL_UART_OVF_CNT_EN
    eovf = ovf[d];
`else
    eovf = 0;
`endif
    chk($sformatf("d%0d ack_o", d), 64'(a), (g_pend[d] < 0) ? 64'd0 : (64'd1 << g_pend[d]));
    chk($sformatf("d%0d out_o", d), 64'(o), 64'(eo));
    chk($sformatf("d%0d valid_o", d), 64'(v), 64'(msz[d] > 0));
    chk($sformatf("d%0d count_o", d), 64'(c), 64'(msz[d]));
    chk($sformatf("d%0d full_o", d), 64'(f), 64'(msz[d] == int'(DEPTH)));
    chk($sformatf("d%0d empty_o", d), 64'(e), 64'(msz[d] == 0));
    chk($sformatf("d%0d ovf_cnt_o", d), 64'(ov), 64'(eovf));
  endtask

  // Apply one clock edge's worth of rules to the model
  task automatic model_step(input int d);
    int g;
    if (rst_i) begin
      model_reset(d);
      return;
    end
    if (blk_pend[d] && ovf[d] < 65535) ovf[d]++;
    if (pop_pend[d]) begin
      if (hold(d)) lastpop[d] = ml[d][0];
      for (int i = 0; i < int'(DEPTH) - 1; i++) ml[d][i] = ml[d][i+1];
      msz[d]--;
    end
    g = g_pend[d];
    if (g >= 0) begin
      ml[d][msz[d]] = dat[d][g];
      msz[d]++;
      lastg[d] = g;
      wr[d][g] = 1'b0;
    end
  endtask

  // Requests are held until acked; new requests carry fresh random data
  task automatic run(input int cycles, input int req_pct, input int rdy_pct, input int rst_pct);
    repeat (cycles) begin
      rst_i = ($urandom_range(99) < rst_pct);
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < nsrc(d); s++) begin
          if (!wr[d][s] && $urandom_range(99) < req_pct) begin
            wr[d][s]  = 1'b1;
            dat[d][s] = $urandom;
          end
        end
        rdy[d] = ($urandom_range(99) < rdy_pct);
      end
      @(negedge clk_i);
      for (int d = 0; d < 2; d++) begin
        g_pend[d]   = exp_grant(d);
        pop_pend[d] = !rst_i && msz[d] > 0 && rdy[d];
        blk_pend[d] = (|wr[d]) && msz[d] == int'(DEPTH);
        check_dut(d);
      end
      @(posedge clk_i);
      #1;
      for (int d = 0; d < 2; d++) model_step(d);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    for (int d = 0; d < 2; d++) begin
      wr[d]  = '0;
      rdy[d] = 1'b0;
      for (int s = 0; s < 3; s++) dat[d][s] = '0;
    end
    repeat (2) @(posedge clk_i);
    #1;
    for (int d = 0; d < 2; d++) model_reset(d);

    run(3, 0, 0, 0);      // idle after reset
    run(8, 100, 0, 0);    // fill to full, then blocked requests
    run(2, 100, 100, 0);  // full blocks pushes even while popping
    run(1, 0, 0, 100);    // reset with a full FIFO
    run(2, 100, 0, 0);    // bring occupancy to 2
    run(12, 100, 100, 0); // steady push+pop, pointers wrap
    run(6, 0, 100, 0);    // drain to empty, observe held/zero output
    run(3, 100, 0, 0);    // queue 3 words
    run(1, 0, 0, 100);    // reset discards them
    run(2, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      run(100, $urandom_range(100), $urandom_range(100), 1);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
